// File: rtl/tsc_mem_responder.sv
// -----------------------------------------------------------------------------
// tsc_mem_responder
//
// Slave end of the TSC CPU read-only memory bus. A read request (readM held
// high) is accepted in IDLE, waits READ_LATENCY cycles, then the addressed word
// is driven onto the shared data bus together with inputReady for
// STABLE_CYCLES cycles. The word image is written through a side load port
// that works in any state and is never cleared by reset.
//
// Ports:
//   clk         in     1          system clock, rising edge
//   reset_n     in     1          asynchronous active-low reset
//   readM       in     1          CPU read request (level)
//   address     in     WORD_SIZE  CPU read address, only low ADDR_BITS decoded
//   data        inout  WORD_SIZE  shared data bus, driven only while serving
//   inputReady  out    1          data-valid strobe
//   load_en     in     1          image load write enable
//   load_addr   in     ADDR_BITS  image load word address
//   load_data   in     WORD_SIZE  image load write data
//   read_count  out    WORD_SIZE  completed reads, wraps
// -----------------------------------------------------------------------------
module tsc_mem_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 3,   // legal 1..15
  parameter int STABLE_CYCLES = 1    // legal 1..15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] read_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Counters are preloaded with (N-1) so that a value of zero marks the last
  // cycle of the latency / stable window.
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] STB_INIT = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_lat_cnt;
  logic [3:0]           r_stb_cnt;
  logic [ADDR_BITS-1:0] r_addr_q;
  logic [WORD_SIZE-1:0] r_dout_q;
  logic                 r_ready;
  logic [WORD_SIZE-1:0] r_read_count;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  state_t               w_state_nxt;
  logic [3:0]           w_lat_nxt;
  logic [3:0]           w_stb_nxt;
  logic                 w_accept;
  logic                 w_serve;

  // Upper address bits are intentionally not decoded (address wraps).
  logic                 w_addr_unused;
  assign w_addr_unused = ^address[WORD_SIZE-1:ADDR_BITS];

  // Next-state and counter decode for the request/serve sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_stb_nxt   = r_stb_cnt;
    w_accept    = 1'b0;
    w_serve     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (readM) begin
          w_state_nxt = ST_WAIT;
          w_lat_nxt   = LAT_INIT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A request withdrawn before data is ready is dropped silently.
        if (!readM) begin
          w_state_nxt = ST_IDLE;
        end else if (r_lat_cnt == 4'd0) begin
          w_state_nxt = ST_DRIVE;
          w_stb_nxt   = STB_INIT;
          w_serve     = 1'b1;
        end else begin
          w_lat_nxt   = r_lat_cnt - 4'd1;
        end
      end
      ST_DRIVE: begin
        // The stable window runs to completion regardless of readM.
        if (r_stb_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stb_nxt   = r_stb_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state, latched address/data, strobe and read counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_lat_cnt    <= 4'd0;
      r_stb_cnt    <= 4'd0;
      r_addr_q     <= '0;
      r_dout_q     <= '0;
      r_ready      <= 1'b0;
      r_read_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_stb_cnt <= w_stb_nxt;
      // Strobe is a flop mirroring the next state, so the bus enable never
      // depends combinationally on readM.
      r_ready   <= (w_state_nxt == ST_DRIVE);
      if (w_accept) begin
        r_addr_q <= address[ADDR_BITS-1:0];
      end
      if (w_serve) begin
        // Sampled before this edge's load-port write lands: read-before-write.
        r_dout_q     <= r_mem[r_addr_q];
        r_read_count <= r_read_count + WORD_SIZE'(1);
      end
    end
  end

  // Image storage; deliberately outside the reset domain so it survives reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  assign data       = r_ready ? r_dout_q : {WORD_SIZE{1'bz}};
  assign inputReady = r_ready;
  assign read_count = r_read_count;

endmodule

// File: tb/tb_tsc_mem_responder.sv
// Bench for tsc_mem_responder. Two instances: u_dut1 with latency 3 / stable 1
// and u_dut2 with latency 1 / stable 2. They share clock, reset and the load
// port, so both images hold the same words. The data buses carry pull-ups, so
// a released bus reads as all ones (no test word is 16'hFFFF).
module tb_tsc_mem_responder;

  localparam logic [15:0] FLOAT = 16'hFFFF;
  localparam int RL1 = 3;
  localparam int SC1 = 1;
  localparam int RL2 = 1;
  localparam int SC2 = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM, readM2;
  logic [15:0] address, address2;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  wire  [15:0] data1_w, data2_w;
  logic        rdy1, rdy2;
  logic [15:0] cnt1, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (data1_w[g]);
    pullup (data2_w[g]);
  end

  tsc_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .READ_LATENCY(RL1), .STABLE_CYCLES(SC1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .readM(readM), .address(address), .data(data1_w),
    .inputReady(rdy1), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .read_count(cnt1));

  tsc_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .READ_LATENCY(RL2), .STABLE_CYCLES(SC2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .readM(readM2), .address(address2), .data(data2_w),
    .inputReady(rdy2), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .read_count(cnt2));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: each request is a timestamped transaction. A request
  // accepted at edge E is served at edge E+RL if readM stays high through it,
  // and its strobe window covers edges [E+RL, E+RL+SC). The next request can be
  // accepted no earlier than edge E+RL+SC+1.
  // ---------------------------------------------------------------------------
  logic [15:0] mem_m [256];
  int          ecnt = 0;
  bit          pend   [2];
  int          acc_e  [2];
  int          win_s  [2];
  int          win_e  [2];
  int          free_e [2];
  logic [15:0] dval   [2];
  logic [15:0] cnt_m  [2];
  logic [7:0]  addr_m [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend[d]   = 1'b0;
      win_s[d]  = 0;
      win_e[d]  = 0;
      free_e[d] = 0;
      cnt_m[d]  = 16'h0000;
      dval[d]   = 16'h0000;
    end
  endtask

  task automatic model_edge();
    bit          rm;
    logic [15:0] a;
    int          rl, sc;
    ecnt++;
    for (int d = 0; d < 2; d++) begin
      rm = (d == 0) ? readM : readM2;
      a  = (d == 0) ? address : address2;
      rl = (d == 0) ? RL1 : RL2;
      sc = (d == 0) ? SC1 : SC2;
      if (pend[d]) begin
        if (!rm) begin
          pend[d]   = 1'b0;
          free_e[d] = ecnt + 1;
        end else if (ecnt == acc_e[d] + rl) begin
          pend[d]   = 1'b0;
          dval[d]   = mem_m[addr_m[d]];
          cnt_m[d]  = cnt_m[d] + 16'h0001;
          win_s[d]  = ecnt;
          win_e[d]  = ecnt + sc;
          free_e[d] = ecnt + sc + 1;
        end
      end else if (ecnt >= free_e[d] && rm) begin
        pend[d]   = 1'b1;
        acc_e[d]  = ecnt;
        addr_m[d] = a[7:0];
      end
    end
    // Writes of this edge are seen only by later reads.
    if (load_en) mem_m[load_addr] = load_data;
  endtask

  function automatic bit exp_ready(input int d);
    return (win_s[d] <= ecnt) && (ecnt < win_e[d]);
  endfunction

  // Model update on every edge (or asynchronous reset), then compare 1 ns later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    chk("m_rdy1",  {15'd0, rdy1}, {15'd0, exp_ready(0)});
    chk("m_data1", data1_w, exp_ready(0) ? dval[0] : FLOAT);
    chk("m_cnt1",  cnt1, cnt_m[0]);
    chk("m_rdy2",  {15'd0, rdy2}, {15'd0, exp_ready(1)});
    chk("m_data2", data2_w, exp_ready(1) ? dval[1] : FLOAT);
    chk("m_cnt2",  cnt2, cnt_m[1]);
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    nclk(1);
    load_en   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; readM = 1'b0; readM2 = 1'b0; address = 16'h0000; address2 = 16'h0000;
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
    nclk(2);
    chk("rst_rdy",  {15'd0, rdy1}, 16'h0000);
    chk("rst_data", data1_w, FLOAT);
    chk("rst_cnt",  cnt1, 16'h0000);
    reset_n = 1'b1;

    load_word(8'h00, 16'h6000);
    load_word(8'h01, 16'h6101);
    load_word(8'h03, 16'hfc1c);
    load_word(8'h05, 16'h0505);
    load_word(8'h07, 16'h7777);
    nclk(1);

    // Read of word 0: accepted at edge N, data from edge N+3.
    readM = 1'b1; address = 16'h0000;
    nclk(4);
    chk("t1_rdy",  {15'd0, rdy1}, 16'h0001);
    chk("t1_data", data1_w, 16'h6000);
    chk("t1_cnt",  cnt1, 16'h0001);
    // readM held, address moves to 1: one IDLE edge, then re-acceptance.
    address = 16'h0001;
    nclk(1);
    chk("t1_rel_data", data1_w, FLOAT);
    chk("t1_rel_rdy",  {15'd0, rdy1}, 16'h0000);
    nclk(4);
    chk("t2_rdy",  {15'd0, rdy1}, 16'h0001);
    chk("t2_data", data1_w, 16'h6101);
    chk("t2_cnt",  cnt1, 16'h0002);
    readM = 1'b0;
    nclk(2);

    // One-cycle request is withdrawn in WAIT.
    readM = 1'b1; address = 16'h0000;
    nclk(1);
    readM = 1'b0;
    nclk(5);
    chk("t3_rdy",  {15'd0, rdy1}, 16'h0000);
    chk("t3_data", data1_w, FLOAT);
    chk("t3_cnt",  cnt1, 16'h0002);

    // Upper address bits ignored.
    readM = 1'b1; address = 16'hFF03;
    nclk(4);
    chk("t4_data", data1_w, 16'hfc1c);
    chk("t4_cnt",  cnt1, 16'h0003);
    readM = 1'b0;
    nclk(2);
    readM = 1'b1; address = 16'h0105;
    nclk(4);
    chk("wrap_data", data1_w, 16'h0505);
    chk("wrap_cnt",  cnt1, 16'h0004);
    readM = 1'b0;
    nclk(2);

    // Asynchronous reset in the middle of DRIVE; image survives.
    readM = 1'b1; address = 16'h0000;
    nclk(4);
    chk("t5_pre_rdy", {15'd0, rdy1}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rdy",  {15'd0, rdy1}, 16'h0000);
    chk("t5_data", data1_w, FLOAT);
    chk("t5_cnt",  cnt1, 16'h0000);
    #1 reset_n = 1'b1;
    nclk(4);
    chk("t5_reread", data1_w, 16'h6000);
    chk("t5_cnt1",   cnt1, 16'h0001);
    readM = 1'b0;
    nclk(2);

    // Latency 1 / stable 2 instance, load collides with the serve edge.
    readM2 = 1'b1; address2 = 16'h0007;
    nclk(1);
    load_en = 1'b1; load_addr = 8'h07; load_data = 16'h7AAA;
    nclk(1);
    load_en = 1'b0;
    chk("t6_rdy_a",  {15'd0, rdy2}, 16'h0001);
    chk("t6_old_a",  data2_w, 16'h7777);
    chk("t6_cnt_a",  cnt2, 16'h0001);
    nclk(1);
    chk("t6_rdy_b",  {15'd0, rdy2}, 16'h0001);
    chk("t6_old_b",  data2_w, 16'h7777);
    readM2 = 1'b0;
    nclk(1);
    chk("t6_rdy_end", {15'd0, rdy2}, 16'h0000);
    nclk(1);
    readM2 = 1'b1; address2 = 16'h0007;
    nclk(2);
    chk("t6_new",   data2_w, 16'h7AAA);
    chk("t6_cnt_b", cnt2, 16'h0002);
    readM2 = 1'b0;
    nclk(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
